mcvram_arbiter: RTL
===================

Name: mcvram_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM between two requesters: the mcvideo scanout fetch and the CPU.
- Video fetch has priority. A starvation counter guarantees the CPU a slot under sustained video traffic.
- Sits between mcvideo (pixel fetch side), the CPU bus bridge and the framebuffer RAM macro.
- Issues at most one RAM access per clock, in acceptance order.

Parameters:
ADDRESS_WIDTH, 13, framebuffer word address width
DATA_WIDTH, 8, RAM word width
CPU_STARVE_LIMIT, 8, consecutive lost cycles after which a pending CPU request beats video; 0 disables the override

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-high reset
video_request  input  1  video fetch request; held with address until accepted
video_address  input  ADDRESS_WIDTH  video read address
video_accept  output  1  combinational; transfer occurs when video_request and video_accept are both high
video_data  output  DATA_WIDTH  returned video read data
video_valid  output  1  one-cycle pulse, video_data valid
cpu_request  input  1  CPU access request; held with all fields until accepted
cpu_write  input  1  1 = write, 0 = read
cpu_address  input  ADDRESS_WIDTH  CPU address
cpu_write_data  input  DATA_WIDTH  CPU write data
cpu_accept  output  1  combinational transfer strobe
cpu_read_data  output  DATA_WIDTH  returned CPU read data
cpu_read_valid  output  1  one-cycle pulse, cpu_read_data valid
ram_address  output  ADDRESS_WIDTH  registered RAM address
ram_write_enable  output  1  registered RAM write strobe
ram_write_data  output  DATA_WIDTH  registered RAM write data
ram_read_data  input  DATA_WIDTH  RAM output; valid the cycle after the address is presented

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; starve counter 0; both return-pipeline tags GRANT_NONE.
  - In-flight reads are discarded and never produce a valid.
- Grant in cycle N (combinational):
  - Grant the CPU if cpu_request and (!video_request or (CPU_STARVE_LIMIT != 0 and counter == CPU_STARVE_LIMIT)).
  - Otherwise grant video if video_request.
  - Otherwise GRANT_NONE.
  - Exactly one of video_accept / cpu_accept is high per cycle, or neither.
- Issue:
  - At the edge ending cycle N, the winner's address is registered into ram_address. For a CPU write, cpu_write_data goes into ram_write_data and ram_write_enable = 1 for cycle N+1 only.
  - On GRANT_NONE: ram_write_enable = 0 and ram_address holds its value.
- Read return (latency 3):
  - The grant tag (GRANT_VIDEO / GRANT_CPU_READ) advances through a two-stage pipeline.
  - ram_read_data is stable during cycle N+2 and is registered into video_data or cpu_read_data at the end of N+2.
  - The matching valid pulses in cycle N+3.
  - Back-to-back grants produce back-to-back valids.
  - Data outputs hold their last value when valid is low.
- Writes produce no valid.
- Read-after-write to the same address is ordered correctly: issue order equals acceptance order.
- Starve counter:
  - Increments (saturating at CPU_STARVE_LIMIT) each cycle cpu_request is high and the CPU is not granted.
  - Clears on CPU grant or when cpu_request is low.
- Simultaneous requests with counter below the limit: video wins and the counter increments.
- A requester dropping its request before accept is a protocol violation. The arbiter uses whatever is present at sampling, with no recovery logic.

Decomposition:
- Package mcvram_package:
  - grant_t enum: GRANT_NONE, GRANT_VIDEO, GRANT_CPU_READ, GRANT_CPU_WRITE.
  - Default width constants.
- Sub-module mcvram_return_pipe: the two-stage tag pipeline plus output data/valid registers for both requesters.
- Grant logic, starve counter and RAM issue registers stay in the top module.

Test Plan:
- Video read at 0x0123, RAM model holds 0x5A, request in cycle 10 -> video_accept high in cycle 10, ram_address = 0x0123 in cycle 11, video_valid with 0x5A in cycle 13 only.
- Video and CPU read (0x0200, holds 0x33) both requested in cycle 5 -> video_accept in 5, cpu_accept in 6, cpu_read_valid with 0x33 in 9.
- CPU write 0xA5 to 0x0010 in cycle 20, then read 0x0010 in cycle 21 -> ram_write_enable high in cycle 21 only, cpu_read_valid with 0xA5 in cycle 24.
- video_request held high continuously, CPU read pending from cycle 0, limit 8 -> cpu_accept in cycle 8 with video_accept low that cycle, counter 0 in cycle 9; repeats every 9 cycles.
- CPU_STARVE_LIMIT = 0, video held high for 100 cycles with CPU pending -> cpu_accept never asserts; CPU accepted the cycle after video_request drops.
- Video read accepted in cycle 30, reset asserted in cycle 31 and released in 32 -> all outputs 0 immediately on assertion, no video_valid in cycle 33.

Source files
------------

// File: rtl/mcvram_package.sv
// Shared types and default sizing for the mcvram framebuffer arbiter.
package mcvram_package;

  localparam int unsigned DEFAULT_ADDRESS_WIDTH    = 13;
  localparam int unsigned DEFAULT_DATA_WIDTH       = 8;
  localparam int unsigned DEFAULT_CPU_STARVE_LIMIT = 8;

  typedef enum logic [1:0] {
    GRANT_NONE      = 2'd0,
    GRANT_VIDEO     = 2'd1,
    GRANT_CPU_READ  = 2'd2,
    GRANT_CPU_WRITE = 2'd3
  } grant_t;

endpackage

// File: rtl/mcvram_return_pipe.sv
// Carries read grant tags alongside the RAM latency and steers returning
// read data to the requester that issued the read.
module mcvram_return_pipe
  import mcvram_package::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  grant_t                issue_grant,
  input  logic [DATA_WIDTH-1:0] ram_read_data,
  output logic [DATA_WIDTH-1:0] video_data,
  output logic                  video_valid,
  output logic [DATA_WIDTH-1:0] cpu_read_data,
  output logic                  cpu_read_valid
);

  grant_t                stage1_d, stage1_q;
  grant_t                stage2_d, stage2_q;
  logic [DATA_WIDTH-1:0] video_data_d, video_data_q;
  logic                  video_valid_d, video_valid_q;
  logic [DATA_WIDTH-1:0] cpu_read_data_d, cpu_read_data_q;
  logic                  cpu_read_valid_d, cpu_read_valid_q;

  always_comb begin
    stage1_d         = GRANT_NONE;
    stage2_d         = stage1_q;
    video_data_d     = video_data_q;
    video_valid_d    = 1'b0;
    cpu_read_data_d  = cpu_read_data_q;
    cpu_read_valid_d = 1'b0;

    // Writes return nothing, so only read tags enter the pipe.
    if (issue_grant == GRANT_VIDEO || issue_grant == GRANT_CPU_READ) begin
      stage1_d = issue_grant;
    end

    if (stage2_q == GRANT_VIDEO) begin
      video_data_d  = ram_read_data;
      video_valid_d = 1'b1;
    end
    if (stage2_q == GRANT_CPU_READ) begin
      cpu_read_data_d  = ram_read_data;
      cpu_read_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage1_q         <= GRANT_NONE;
      stage2_q         <= GRANT_NONE;
      video_data_q     <= '0;
      video_valid_q    <= 1'b0;
      cpu_read_data_q  <= '0;
      cpu_read_valid_q <= 1'b0;
    end else begin
      stage1_q         <= stage1_d;
      stage2_q         <= stage2_d;
      video_data_q     <= video_data_d;
      video_valid_q    <= video_valid_d;
      cpu_read_data_q  <= cpu_read_data_d;
      cpu_read_valid_q <= cpu_read_valid_d;
    end
  end

  assign video_data     = video_data_q;
  assign video_valid    = video_valid_q;
  assign cpu_read_data  = cpu_read_data_q;
  assign cpu_read_valid = cpu_read_valid_q;

endmodule

// File: rtl/mcvram_arbiter.sv
// Single-port framebuffer RAM arbiter: video fetch has priority, with a
// starvation counter that eventually forces a pending CPU access through.
module mcvram_arbiter
  import mcvram_package::*;
#(
  parameter int unsigned ADDRESS_WIDTH    = DEFAULT_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH       = DEFAULT_DATA_WIDTH,
  parameter int unsigned CPU_STARVE_LIMIT = DEFAULT_CPU_STARVE_LIMIT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     video_request,
  input  logic [ADDRESS_WIDTH-1:0] video_address,
  output logic                     video_accept,
  output logic [DATA_WIDTH-1:0]    video_data,
  output logic                     video_valid,
  input  logic                     cpu_request,
  input  logic                     cpu_write,
  input  logic [ADDRESS_WIDTH-1:0] cpu_address,
  input  logic [DATA_WIDTH-1:0]    cpu_write_data,
  output logic                     cpu_accept,
  output logic [DATA_WIDTH-1:0]    cpu_read_data,
  output logic                     cpu_read_valid,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic                     ram_write_enable,
  output logic [DATA_WIDTH-1:0]    ram_write_data,
  input  logic [DATA_WIDTH-1:0]    ram_read_data
);

  localparam int unsigned STARVE_WIDTH =
    (CPU_STARVE_LIMIT < 1) ? 1 : $clog2(CPU_STARVE_LIMIT + 1);
  localparam logic [STARVE_WIDTH-1:0] STARVE_MAX = STARVE_WIDTH'(CPU_STARVE_LIMIT);

  grant_t                   grant_c;
  logic                     cpu_starved_c;
  logic [STARVE_WIDTH-1:0]  starve_d, starve_q;
  logic [ADDRESS_WIDTH-1:0] ram_address_d, ram_address_q;
  logic                     ram_write_enable_d, ram_write_enable_q;
  logic [DATA_WIDTH-1:0]    ram_write_data_d, ram_write_data_q;

  // Accepts are held low during reset so the outputs are quiet while it is asserted.
  always_comb begin
    grant_c       = GRANT_NONE;
    cpu_starved_c = (CPU_STARVE_LIMIT != 0) && (starve_q == STARVE_MAX);
    if (!reset) begin
      if (cpu_request && (!video_request || cpu_starved_c)) begin
        grant_c = cpu_write ? GRANT_CPU_WRITE : GRANT_CPU_READ;
      end else if (video_request) begin
        grant_c = GRANT_VIDEO;
      end
    end
  end

  assign video_accept = (grant_c == GRANT_VIDEO);
  assign cpu_accept   = (grant_c == GRANT_CPU_READ) || (grant_c == GRANT_CPU_WRITE);

  always_comb begin
    ram_address_d      = ram_address_q;
    ram_write_enable_d = 1'b0;
    ram_write_data_d   = ram_write_data_q;
    starve_d           = '0;

    case (grant_c)
      GRANT_VIDEO:    ram_address_d = video_address;
      GRANT_CPU_READ: ram_address_d = cpu_address;
      GRANT_CPU_WRITE: begin
        ram_address_d      = cpu_address;
        ram_write_data_d   = cpu_write_data;
        ram_write_enable_d = 1'b1;
      end
      default: ;
    endcase

    // Count cycles a waiting CPU loses, saturating at the limit.
    if (cpu_request && !cpu_accept) begin
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + STARVE_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_q           <= '0;
      ram_address_q      <= '0;
      ram_write_enable_q <= 1'b0;
      ram_write_data_q   <= '0;
    end else begin
      starve_q           <= starve_d;
      ram_address_q      <= ram_address_d;
      ram_write_enable_q <= ram_write_enable_d;
      ram_write_data_q   <= ram_write_data_d;
    end
  end

  assign ram_address      = ram_address_q;
  assign ram_write_enable = ram_write_enable_q;
  assign ram_write_data   = ram_write_data_q;

  mcvram_return_pipe #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_return_pipe (
    .clock          (clock),
    .reset          (reset),
    .issue_grant    (grant_c),
    .ram_read_data  (ram_read_data),
    .video_data     (video_data),
    .video_valid    (video_valid),
    .cpu_read_data  (cpu_read_data),
    .cpu_read_valid (cpu_read_valid)
  );

endmodule
